// File: rtl/masku_opseq_ctrl.sv
// Operand sequencing controller for the MASKU re-order path: gathers one 64-bit word per lane,
// assembles lane-ordered beats sized by the remaining vl, and hands them to the re-order stage.
module masku_opseq_ctrl #(
  parameter int unsigned NrLanes = 4,
  parameter int unsigned VlWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    vinsn_valid_i,
  output logic                    vinsn_ready_o,
  input  logic [1:0]              vinsn_vsew_i,
  input  logic [VlWidth-1:0]      vinsn_vl_i,
  input  logic                    flush_i,
  input  logic [NrLanes*64-1:0]   lane_operand_i,
  input  logic [NrLanes-1:0]      lane_valid_i,
  output logic [NrLanes-1:0]      lane_ready_o,
  output logic [NrLanes*64-1:0]   seq_operand_o,
  output logic [1:0]              seq_vsew_o,
  output logic [VlWidth-1:0]      seq_nelem_o,
  output logic                    seq_last_o,
  output logic                    seq_valid_o,
  input  logic                    seq_ready_i,
  output logic                    done_o
);

  localparam logic [1:0] EW8 = 2'd0;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e state_reg, state_next;

  logic [VlWidth-1:0]    col_rem_reg;
  logic [1:0]            vsew_reg;
  logic [NrLanes*64-1:0] seq_operand_reg;
  logic [VlWidth-1:0]    seq_nelem_reg;
  logic                  seq_last_reg;
  logic                  seq_valid_reg;
  logic                  done_reg;

  logic [NrLanes-1:0]    slot_v;
  logic [NrLanes-1:0]    need_mask;
  logic [NrLanes-1:0]    lane_hs;
  logic [NrLanes*64-1:0] beat_word;
  logic [VlWidth-1:0]    elem_per_beat;
  logic [VlWidth-1:0]    nelem_next;
  logic                  last_next;
  logic                  run;
  logic                  vinsn_hs;
  logic                  out_free;
  logic                  beat_fire;
  logic                  last_hs;

  assign run           = (state_reg == RUN);
  assign vinsn_ready_o = (state_reg == IDLE) && !flush_i;
  assign vinsn_hs      = vinsn_valid_i && vinsn_ready_o;
  assign lane_ready_o  = (run && (col_rem_reg != '0)) ? (~slot_v & need_mask) : '0;
  assign lane_hs       = lane_valid_i & lane_ready_o;
  assign out_free      = !seq_valid_reg || seq_ready_i;
  assign last_hs       = seq_valid_reg && seq_ready_i && seq_last_reg;

  // A lane counts as present if its slot is held or its word arrives this cycle, so the
  // beat can load on the same edge as the final lane handshake.
  assign beat_fire = run && !flush_i && (col_rem_reg != '0) && out_free &&
                     (&(slot_v | lane_hs | ~need_mask));

  always_comb begin
    elem_per_beat = VlWidth'(NrLanes);
    unique case (vsew_reg)
      2'd0:    elem_per_beat = VlWidth'(NrLanes * 8);
      2'd1:    elem_per_beat = VlWidth'(NrLanes * 4);
      2'd2:    elem_per_beat = VlWidth'(NrLanes * 2);
      default: elem_per_beat = VlWidth'(NrLanes);
    endcase
  end

  assign nelem_next = (col_rem_reg < elem_per_beat) ? col_rem_reg : elem_per_beat;
  assign last_next  = (col_rem_reg <= elem_per_beat);

  for (genvar gi = 0; gi < NrLanes; gi++) begin : g_lane
    logic [63:0] data_reg;
    logic        v_reg;

    // Element i sits in lane i mod NrLanes, so lane gi carries data iff more than gi remain.
    assign need_mask[gi] = (col_rem_reg > VlWidth'(gi));
    assign slot_v[gi]    = v_reg;
    assign beat_word[gi*64 +: 64] = !need_mask[gi] ? 64'd0 :
                                    (v_reg ? data_reg : lane_operand_i[gi*64 +: 64]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        v_reg    <= 1'b0;
        data_reg <= '0;
      end else if (flush_i || beat_fire) begin
        v_reg    <= 1'b0;
      end else if (lane_hs[gi]) begin
        v_reg    <= 1'b1;
        data_reg <= lane_operand_i[gi*64 +: 64];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (vinsn_hs && (vinsn_vl_i != '0)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (flush_i || last_hs) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_rem_reg     <= '0;
      vsew_reg        <= EW8;
      seq_operand_reg <= '0;
      seq_nelem_reg   <= '0;
      seq_last_reg    <= 1'b0;
      seq_valid_reg   <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      if (flush_i) begin
        col_rem_reg <= '0;
      end else if (vinsn_hs) begin
        col_rem_reg <= vinsn_vl_i;
        vsew_reg    <= vinsn_vsew_i;
      end else if (beat_fire) begin
        col_rem_reg <= col_rem_reg - nelem_next;
      end

      if (flush_i) begin
        seq_valid_reg <= 1'b0;
      end else if (beat_fire) begin
        seq_valid_reg   <= 1'b1;
        seq_operand_reg <= beat_word;
        seq_nelem_reg   <= nelem_next;
        seq_last_reg    <= last_next;
      end else if (seq_ready_i) begin
        seq_valid_reg <= 1'b0;
      end

      done_reg <= !flush_i && ((vinsn_hs && (vinsn_vl_i == '0)) || (run && last_hs));
    end
  end

  assign seq_operand_o = seq_operand_reg;
  assign seq_vsew_o    = vsew_reg;
  assign seq_nelem_o   = seq_nelem_reg;
  assign seq_last_o    = seq_last_reg;
  assign seq_valid_o   = seq_valid_reg;
  assign done_o        = done_reg;

endmodule
